// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for pipeline stage registers.
// Stage payloads are packed structs so each stage sizes its register as
// WIDTH = $bits(<stage>_t). Also holds the skid-buffer state encoding and the
// default stall-counter width.
package pipe_stage_reg_pkg;

    localparam int unsigned PIPE_CNT_W = 16;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;

    // Occupancy state of the two-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Control word carried by every stage.
    typedef struct packed {
        logic              reg_we;
        logic              mem_re;
        logic              mem_we;
        logic              branch;
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] rd;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
    } id_ex_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] store_val;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] wb_val;
    } mem_wb_t;

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// Two-entry skid buffer: main register feeds downstream, skid register
// catches the one entry accepted while downstream stalls, so up_ready comes
// straight from a flop.
// Ports: clk, rst_n (async active-low), flush (drop held entries),
//        up_valid/up_ready/up_data (upstream), dn_valid/dn_ready/dn_data
//        (downstream, main register), skid_valid (skid entry held).
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic             skid_valid
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             up_fire, dn_fire;

    assign dn_valid   = (state_q != BUF_EMPTY);
    assign skid_valid = (state_q == BUF_FULL);
    assign up_ready   = !skid_valid;
    assign dn_data    = main_q;
    assign up_fire    = up_valid & up_ready;
    assign dn_fire    = dn_valid & dn_ready;

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state; payloads load only on an accepted (non-flushed) transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (up_fire) begin
                        state_d = BUF_ONE;
                        main_d  = up_data;
                    end
                end
                BUF_ONE: begin
                    if (up_fire && dn_fire) begin
                        main_d = up_data;
                    end else if (up_fire) begin
                        state_d = BUF_FULL;
                        skid_d  = up_data;
                    end else if (dn_fire) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (dn_fire) begin
                        state_d = BUF_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: packed payload under valid/ready, with flush,
// optional skid buffer (SKID=1) or single register (SKID=0), and a
// saturating stall counter.
// Ports: clk, rst_n (async active-low), flush, clr_stats,
//        up_valid/up_ready/up_data, dn_valid/dn_ready/dn_data,
//        occupancy (entries held), stall_cnt (dn_valid & !dn_ready cycles).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             clr_stats,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             main_v;
    logic             skid_v;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(
                .WIDTH (WIDTH)
            ) u_skid_buf (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush      (flush),
                .up_valid   (up_valid),
                .up_ready   (up_ready),
                .up_data    (up_data),
                .dn_valid   (main_v),
                .dn_ready   (dn_ready),
                .dn_data    (dn_data),
                .skid_valid (skid_v)
            );
        end else begin : g_single
            logic             main_v_q, main_v_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic             up_fire, dn_fire;

            // Ready passes through combinationally when the slot drains this cycle.
            assign up_ready = !main_v_q | dn_ready;
            assign up_fire  = up_valid & up_ready;
            assign dn_fire  = main_v_q & dn_ready;
            assign main_v   = main_v_q;
            assign skid_v   = 1'b0;
            assign dn_data  = main_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_v_q <= 1'b0;
                    main_q   <= '0;
                end else begin
                    main_v_q <= main_v_d;
                    main_q   <= main_d;
                end
            end

            always_comb begin
                main_v_d = main_v_q;
                main_d   = main_q;
                if (flush) begin
                    main_v_d = 1'b0;
                end else if (up_fire) begin
                    main_v_d = 1'b1;
                    main_d   = up_data;
                end else if (dn_fire) begin
                    main_v_d = 1'b0;
                end
            end
        end
    endgenerate

    assign dn_valid  = main_v;
    assign occupancy = 2'(main_v) + 2'(skid_v);
    assign stall_cnt = stall_cnt_q;

    // Saturating stall counter; clear wins over increment, flush leaves it alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_stats) begin
            stall_cnt_d = '0;
        end else if (main_v && !dn_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1/CNT_W=16 instance and one
// SKID=0/CNT_W=4 instance, directed vectors plus a random phase, with a
// FIFO scoreboard per instance checked by a negedge monitor.
module tb_pipe_stage_reg;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        flush1 = 1'b0, clr1 = 1'b0, uv1 = 1'b0, dr1 = 1'b0;
    logic [31:0] ud1 = '0;
    logic        ur1, dv1;
    logic [31:0] dd1;
    logic [1:0]  occ1;
    logic [15:0] cnt1;

    logic        flush0 = 1'b0, clr0 = 1'b0, uv0 = 1'b0, dr0 = 1'b0;
    logic [31:0] ud0 = '0;
    logic        ur0, dv0;
    logic [31:0] dd0;
    logic [1:0]  occ0;
    logic [3:0]  cnt0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sbq1[$];
    logic [31:0] sbq0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .clr_stats(clr1),
        .up_valid(uv1), .up_ready(ur1), .up_data(ud1),
        .dn_valid(dv1), .dn_ready(dr1), .dn_data(dd1),
        .occupancy(occ1), .stall_cnt(cnt1)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .clr_stats(clr0),
        .up_valid(uv0), .up_ready(ur0), .up_data(ud0),
        .dn_valid(dv0), .dn_ready(dr0), .dn_data(dd0),
        .occupancy(occ0), .stall_cnt(cnt0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, SKID=1 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq1.delete();
        end else begin
            chk("occ1", 32'(occ1), 32'(sbq1.size()));
            chk("dn_valid1", 32'(dv1), 32'(sbq1.size() != 0));
            chk("up_ready1", 32'(ur1), 32'(sbq1.size() < 2));
            if (dv1 && dr1) begin
                n_tests++;
                if (sbq1.size() == 0) begin
                    n_fail++;
                    $display("FAIL dn1_extra: got 0x%08h expected no entry at %0t", dd1, $time);
                end else begin
                    n_tests--;
                    chk("dn1_data", dd1, sbq1.pop_front());
                end
            end
            if (flush1) sbq1.delete();
            else if (uv1 && ur1) sbq1.push_back(ud1);
        end
    end

    // Scoreboard monitor, SKID=0 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq0.delete();
        end else begin
            chk("occ0", 32'(occ0), 32'(sbq0.size()));
            chk("dn_valid0", 32'(dv0), 32'(sbq0.size() != 0));
            chk("up_ready0", 32'(ur0), 32'((sbq0.size() == 0) || dr0));
            if (dv0 && dr0) begin
                n_tests++;
                if (sbq0.size() == 0) begin
                    n_fail++;
                    $display("FAIL dn0_extra: got 0x%08h expected no entry at %0t", dd0, $time);
                end else begin
                    n_tests--;
                    chk("dn0_data", dd0, sbq0.pop_front());
                end
            end
            if (flush0) sbq0.delete();
            else if (uv0 && ur0) sbq0.push_back(ud0);
        end
    end

    initial begin
        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dv1", 32'(dv1), 32'd0);
        chk("rst_dd1", dd1, 32'd0);
        chk("rst_occ1", 32'(occ1), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_dv0", 32'(dv0), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_ur1", 32'(ur1), 32'd1);
        chk("rst_ur0", 32'(ur0), 32'd1);

        // Streaming with one-cycle latency.
        dr1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            uv1 = 1'b1;
            ud1 = 32'(i);
            @(negedge clk);
            if (i > 1) chk("stream_lat", dd1, 32'(i - 1));
        end
        cyc();
        uv1 = 1'b0;
        @(negedge clk);
        chk("stream_last", dd1, 32'd8);

        // Backpressure: one entry lands in skid, then upstream stalls.
        cyc(); uv1 = 1'b1; ud1 = 32'h10; dr1 = 1'b1;
        cyc(); ud1 = 32'h11; dr1 = 1'b0;
        cyc(); ud1 = 32'h12;
        @(negedge clk);
        chk("bp_ur", 32'(ur1), 32'd0);
        chk("bp_occ", 32'(occ1), 32'd2);
        cyc();
        cyc(); dr1 = 1'b1;
        @(negedge clk);
        chk("bp_cnt", 32'(cnt1), 32'd3);
        chk("bp_occ_full", 32'(occ1), 32'd2);
        cyc();
        cyc(); uv1 = 1'b0;
        cyc();
        @(negedge clk);
        chk("bp_drained", 32'(dv1), 32'd0);

        // Flush in FULL with an offered entry.
        cyc(); uv1 = 1'b1; ud1 = 32'h20; dr1 = 1'b0;
        cyc(); ud1 = 32'h21;
        cyc(); ud1 = 32'hDEADBEEF; flush1 = 1'b1;
        cyc(); flush1 = 1'b0; uv1 = 1'b0;
        @(negedge clk);
        chk("flush_full_dv", 32'(dv1), 32'd0);
        chk("flush_full_occ", 32'(occ1), 32'd0);
        chk("flush_keeps_cnt", 32'(cnt1), 32'd5);

        // Flush in ONE with simultaneous up_fire and dn_fire.
        cyc(); uv1 = 1'b1; ud1 = 32'h30; dr1 = 1'b1;
        cyc(); ud1 = 32'hDEADBEEF; flush1 = 1'b1;
        cyc(); flush1 = 1'b0; uv1 = 1'b0;
        @(negedge clk);
        chk("flush_one_dv", 32'(dv1), 32'd0);
        chk("flush_one_occ", 32'(occ1), 32'd0);
        chk("flush_hold_data", dd1, 32'h30);
        repeat (3) cyc();

        // Asynchronous reset in the middle of a stall.
        cyc(); uv1 = 1'b1; ud1 = 32'h40; dr1 = 1'b0;
        cyc(); uv1 = 1'b0;
        cyc();
        @(posedge clk);
        #2;
        chk("pre_rst_dv", 32'(dv1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_dv1", 32'(dv1), 32'd0);
        chk("arst_dd1", dd1, 32'd0);
        chk("arst_cnt1", 32'(cnt1), 32'd0);
        chk("arst_occ1", 32'(occ1), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        dr1 = 1'b1;

        // SKID=0: combinational ready and saturating stall counter.
        cyc(); uv0 = 1'b1; ud0 = 32'h50; dr0 = 1'b0;
        @(negedge clk);
        chk("s0_ur_empty", 32'(ur0), 32'd1);
        for (int k = 0; k < 20; k++) begin
            cyc();
            ud0 = 32'h51;
            #1 dr0 = 1'b1;
            #1 chk("s0_ur_comb_hi", 32'(ur0), 32'd1);
            dr0 = 1'b0;
            #1 chk("s0_ur_comb_lo", 32'(ur0), 32'd0);
        end
        cyc(); clr0 = 1'b1;
        @(negedge clk);
        chk("s0_cnt_sat", 32'(cnt0), 32'd15);
        cyc(); clr0 = 1'b0;
        @(negedge clk);
        chk("s0_cnt_clr", 32'(cnt0), 32'd0);
        cyc(); dr0 = 1'b1;
        @(negedge clk);
        chk("s0_cnt_resume", 32'(cnt0), 32'd1);
        cyc(); uv0 = 1'b0;
        cyc();
        @(negedge clk);
        chk("s0_drained", 32'(dv0), 32'd0);

        // SKID=0 flush with simultaneous up_fire and dn_fire.
        cyc(); uv0 = 1'b1; ud0 = 32'h60; dr0 = 1'b0;
        cyc(); ud0 = 32'h61; dr0 = 1'b1; flush0 = 1'b1;
        cyc(); flush0 = 1'b0; uv0 = 1'b0;
        @(negedge clk);
        chk("s0_flush_dv", 32'(dv0), 32'd0);
        chk("s0_flush_hold", dd0, 32'h60);

        // Random traffic on both instances.
        for (int n = 0; n < 2000; n++) begin
            cyc();
            uv1    = 1'($urandom_range(0, 1));
            ud1    = $urandom();
            dr1    = 1'($urandom_range(0, 1));
            flush1 = ($urandom_range(0, 31) == 0);
            uv0    = 1'($urandom_range(0, 1));
            ud0    = $urandom();
            dr0    = 1'($urandom_range(0, 1));
            flush0 = ($urandom_range(0, 31) == 0);
        end
        cyc();
        uv1 = 1'b0; dr1 = 1'b1; flush1 = 1'b0;
        uv0 = 1'b0; dr0 = 1'b1; flush0 = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("rand_drain1", 32'(dv1), 32'd0);
        chk("rand_drain0", 32'(dv0), 32'd0);

        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
